// File: rtl/mem_dump_controller.sv
// Post-halt data-memory dump sequencer: takes over the memory address path, walks
// every word and streams each dirty word to the UART as a 6-byte frame.
module mem_dump_controller #(
    parameter int RAM_DEPTH      = 1024,
    parameter int CANT_BITS_ADDR = 12,
    parameter int RAM_WIDTH      = 32,
    parameter int READ_LATENCY   = 1
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_start,
    input  logic                        i_abort,
    input  logic                        i_halt_detected,
    input  logic [RAM_WIDTH-1:0]        i_dato_mem,
    input  logic                        i_bit_sucio,
    input  logic                        i_tx_ready,
    output logic [7:0]                  o_tx_data,
    output logic                        o_tx_valid,
    output logic [CANT_BITS_ADDR-1:0]   o_address_debug_unit,
    output logic                        o_control_address_mem,
    output logic                        o_control_write_read_mem,
    output logic                        o_enable_mem_datos,
    output logic                        o_busy,
    output logic                        o_done,
    output logic [$clog2(RAM_DEPTH):0]  o_dirty_count
);

    localparam int IDX_W  = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam int CNT_W  = $clog2(RAM_DEPTH) + 1;
    localparam int WAIT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_WAIT,
        S_CHECK,
        S_SEND,
        S_DONE
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic [IDX_W-1:0]       word_index;
    logic [WAIT_W-1:0]      wait_cnt;
    logic [2:0]             byte_cnt;
    logic [RAM_WIDTH-1:0]   tx_word;
    logic [CNT_W-1:0]       dirty_count;
    logic [15:0]            idx16;
    logic                   last_word;
    logic                   wait_done;
    logic                   last_byte_sent;
    logic                   accept_start;

    assign idx16          = 16'(word_index);
    assign last_word      = (word_index == IDX_W'(RAM_DEPTH - 1));
    assign wait_done      = (wait_cnt == WAIT_W'(READ_LATENCY - 1));
    assign last_byte_sent = i_tx_ready && (byte_cnt == 3'd5);
    assign accept_start   = i_start && i_halt_detected;

    // Abort overrides everything, including a byte handshake in the same cycle.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (accept_start) next_state = S_SETUP;
            S_SETUP: next_state = S_WAIT;
            S_WAIT:  if (wait_done) next_state = S_CHECK;
            S_CHECK: begin
                if (i_bit_sucio)    next_state = S_SEND;
                else if (last_word) next_state = S_DONE;
                else                next_state = S_SETUP;
            end
            S_SEND:  if (last_byte_sent) next_state = last_word ? S_DONE : S_SETUP;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
        if (state != S_IDLE && i_abort) next_state = S_IDLE;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state       <= S_IDLE;
            word_index  <= '0;
            wait_cnt    <= '0;
            byte_cnt    <= '0;
            tx_word     <= '0;
            dirty_count <= '0;
        end else begin
            state <= next_state;
            case (state)
                S_IDLE: begin
                    if (accept_start) begin
                        word_index  <= '0;
                        dirty_count <= '0;
                    end
                end
                S_SETUP: wait_cnt <= '0;
                S_WAIT:  wait_cnt <= wait_cnt + WAIT_W'(1);
                S_CHECK: begin
                    if (!i_abort) begin
                        if (i_bit_sucio) begin
                            tx_word  <= i_dato_mem;
                            byte_cnt <= '0;
                        end else if (!last_word) begin
                            word_index <= word_index + IDX_W'(1);
                        end
                    end
                end
                S_SEND: begin
                    if (!i_abort && i_tx_ready) begin
                        if (byte_cnt == 3'd5) begin
                            byte_cnt    <= '0;
                            dirty_count <= dirty_count + CNT_W'(1);
                            if (!last_word) word_index <= word_index + IDX_W'(1);
                        end else begin
                            byte_cnt <= byte_cnt + 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Frame layout: index high, index low, then data MSB first.
    always_comb begin
        o_tx_data = 8'h00;
        if (state == S_SEND) begin
            case (byte_cnt)
                3'd0:    o_tx_data = idx16[15:8];
                3'd1:    o_tx_data = idx16[7:0];
                3'd2:    o_tx_data = tx_word[31:24];
                3'd3:    o_tx_data = tx_word[23:16];
                3'd4:    o_tx_data = tx_word[15:8];
                default: o_tx_data = tx_word[7:0];
            endcase
        end
    end

    assign o_busy                   = (state != S_IDLE);
    assign o_tx_valid               = (state == S_SEND);
    assign o_done                   = (state == S_DONE);
    assign o_control_address_mem    = o_busy;
    assign o_control_write_read_mem = o_busy;
    assign o_enable_mem_datos       = o_busy;
    assign o_address_debug_unit     = o_busy ? CANT_BITS_ADDR'({word_index, 2'b00}) : '0;
    assign o_dirty_count            = dirty_count;

endmodule
